sensor_conditioner: RTL

- Upstream conditioning stage for the 4-bit sensor-error logic.
- Takes asynchronous, bouncy raw sensor lines and synchronizes each bit through two flops.
- Debounces each bit with a per-channel stability counter.
- Drives a clean, registered sensors vector that the combinational error evaluator consumes directly, plus a one-cycle change pulse and a settled flag.

---
 rtl/sensor_pkg.sv | 11 +
 rtl/sensor_debounce_ch.sv | 48 ++++
 rtl/sensor_conditioner.sv | 52 +++++
 3 files changed

// File: rtl/sensor_pkg.sv
// sensor_pkg: shared sensor types, channel count and saturating add helper
package sensor_pkg;
    localparam int NUM_SENSORS = 4;
    typedef logic [NUM_SENSORS-1:0] sensor_vec_t;
    typedef enum logic {STABLE, PENDING} deb_state_t;
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input int unsigned b);
        int unsigned s;
        s = {24'd0, a} + b;
        return s > 255 ? 8'hFF : s[7:0];
    endfunction
endpackage

// File: rtl/sensor_debounce_ch.sv
// sensor_debounce_ch: one channel of two-flop sync plus stability-counter debounce
// Ports: clk, n_rst (sync active-low), raw (async line), sample_en (strobe),
//        sensor (committed bit), pending (sync2 differs from sensor),
//        commit / abort (single-cycle strobes for the upcoming edge)
module sensor_debounce_ch
    import sensor_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CW = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic n_rst,
    input  logic raw,
    input  logic sample_en,
    output logic sensor,
    output logic pending,
    output logic commit,
    output logic abort
);
    logic sync1, sync2, sensor_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    deb_state_t state;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sensor <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            sensor <= sensor_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // State is implied by whether the synchronized input disagrees with the
    // committed bit; a leftover count in STABLE means the change reverted.
    always_comb begin
        state      = (sync2 != sensor) ? PENDING : STABLE;
        pending    = state == PENDING;
        commit     = pending && sample_en && (int'(cnt) + 1 >= STABLE_CYCLES);
        abort      = !pending && cnt != '0;
        sensor_nxt = commit ? sync2 : sensor;
        cnt_nxt    = (commit || abort) ? '0 : (pending && sample_en) ? cnt + CW'(1) : cnt;
    end
endmodule

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronize and debounce raw sensor lines for the error logic
// Ports: clk, n_rst (sync active-low), raw_sensors (async), sample_en (strobe),
//        sensors (debounced), changed (pulse after any commit), settled (no pending),
//        glitch_count (saturating abort count, only when SENSOR_GLITCH_CNT_EN is defined)
module sensor_conditioner #(
    parameter int NUM_SENSORS   = sensor_pkg::NUM_SENSORS,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_SENSORS-1:0] raw_sensors,
    input  logic                   sample_en,
    output logic [NUM_SENSORS-1:0] sensors,
    output logic                   changed,
    output logic                   settled
`ifdef SENSOR_GLITCH_CNT_EN
    ,
    output logic [7:0]             glitch_count
`endif
);
    import sensor_pkg::*;

    logic [NUM_SENSORS-1:0] pending, commit, abort;

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
        sensor_debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES)) u_ch (
            .clk       (clk),
            .n_rst     (n_rst),
            .raw       (raw_sensors[i]),
            .sample_en (sample_en),
            .sensor    (sensors[i]),
            .pending   (pending[i]),
            .commit    (commit[i]),
            .abort     (abort[i])
        );
    end

    always_ff @(posedge clk) begin
        changed <= n_rst ? |commit : 1'b0;
    end

    assign settled = ~|pending;

`ifdef SENSOR_GLITCH_CNT_EN
    always_ff @(posedge clk) begin
        glitch_count <= n_rst ? sat_add8(glitch_count, $countones(abort)) : 8'd0;
    end
`else
    logic unused_abort;
    assign unused_abort = ^abort;
`endif
endmodule
